// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core types used by the icache refill sequencer:
// the refill FSM state enum and the response record carried into the
// per-word refill buffer.
package bsg_vanilla_pkg;

    // Widest block offset the response record can carry (blocks up to 256 words).
    localparam int icache_refill_offset_width_gp = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } icache_refill_state_e;

    typedef struct packed {
        logic [icache_refill_offset_width_gp-1:0] offset;
        logic [31:0]                              instr;
    } icache_refill_resp_s;

endpackage

// File: rtl/icache_refill_buffer.sv
// Per-word collection buffer for one icache block refill. Accepted
// responses land here unless they hit the head-of-line word, in which case
// they bypass straight to the icache write port in the same cycle.
module icache_refill_buffer
    import bsg_vanilla_pkg::*;
#(
    parameter  int els_p = 4,
    localparam int ptr_width_lp = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    clear_i,
    input  logic                    resp_v_i,
    input  icache_refill_resp_s     resp_i,
    input  logic                    rd_en_i,
    input  logic [ptr_width_lp-1:0] rd_ptr_i,
    output logic [els_p-1:0]        valid_o,
    output logic                    head_v_o,
    output logic [31:0]             head_instr_o
);

    logic [31:0]             data_q [els_p];
    logic [els_p-1:0]        valid_q;
    logic [els_p-1:0]        valid_d;
    logic [ptr_width_lp-1:0] wr_idx_s;
    logic                    head_hit_s;
    logic                    bypass_s;
    logic                    store_s;

    // Head-of-line selection: buffered word first, otherwise a same-cycle bypass.
    always_comb begin
        wr_idx_s   = resp_i.offset[ptr_width_lp-1:0];
        head_hit_s = valid_q[rd_ptr_i];
        bypass_s   = resp_v_i && rd_en_i && !head_hit_s &&
                     (resp_i.offset == icache_refill_offset_width_gp'(rd_ptr_i));
        store_s    = resp_v_i && !bypass_s;
        head_v_o   = rd_en_i && (head_hit_s || bypass_s);
        if (head_hit_s) begin
            head_instr_o = data_q[rd_ptr_i];
        end else begin
            head_instr_o = resp_i.instr;
        end
    end

    // Next valid vector: cleared at the start of each refill, set on each stored word.
    always_comb begin
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = '0;
        end else if (store_s) begin
            valid_d[wr_idx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are reset; they gate every read of the data array.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (store_s) begin
            data_q[wr_idx_s] <= resp_i.instr;
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/icache_refill_sequencer.sv
// Icache refill sequencer: on a miss, requests every word of the block,
// gathers possibly out-of-order responses and writes them into the icache
// strictly in offset order 0..N-1, then pulses refill_done_o.
// Optional build macro ICACHE_REFILL_CRITICAL_WORD_FIRST_EN: requests start
// at the missing word's offset and wrap; write order is unchanged.
module icache_refill_sequencer
    import bsg_vanilla_pkg::*;
#(
    parameter  int icache_tag_width_p           = 12,
    parameter  int icache_entries_p             = 1024,
    parameter  int icache_block_size_in_words_p = 4,
    localparam int pc_width_lp           = icache_tag_width_p + $clog2(icache_entries_p),
    localparam int block_offset_width_lp = $clog2(icache_block_size_in_words_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             miss_v_i,
    input  logic [pc_width_lp-1:0]           miss_pc_i,
    output logic                             miss_ready_o,
    output logic                             req_v_o,
    output logic [pc_width_lp-1:0]           req_addr_o,
    input  logic                             req_ready_i,
    input  logic                             resp_v_i,
    input  logic [block_offset_width_lp-1:0] resp_offset_i,
    input  logic [31:0]                      resp_instr_i,
    output logic                             icache_v_o,
    output logic                             icache_w_o,
    output logic [pc_width_lp-1:0]           icache_w_pc_o,
    output logic [31:0]                      icache_w_instr_o,
    output logic                             refill_done_o,
    output logic                             unexpected_resp_o
);

    localparam int ow_lp = block_offset_width_lp;
    localparam int bw_lp = pc_width_lp - block_offset_width_lp;
    localparam logic [ow_lp-1:0] one_lp  = ow_lp'(1'b1);
    localparam logic [ow_lp-1:0] last_lp = ow_lp'(icache_block_size_in_words_p - 1);

    icache_refill_state_e state_q, state_d;
    logic [bw_lp-1:0]     base_q, base_d;
    logic [ow_lp-1:0]     req_cnt_q, req_cnt_d;
    logic [ow_lp-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ow_lp-1:0]     req_off_s;
    logic                 clear_s, miss_ready_s, req_v_s, wr_v_s, done_s;
    logic                 in_refill_s, resp_accept_s, unexpected_s;
    logic [icache_block_size_in_words_p-1:0] buf_valid_s;
    logic                 head_v_s;
    logic [31:0]          head_instr_s;
    icache_refill_resp_s  resp_s;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    logic [ow_lp-1:0] crit_q, crit_d;
    assign req_off_s = req_cnt_q + crit_q;
`else
    assign req_off_s = req_cnt_q;
`endif

    // Response filter: only first-time words at or beyond the write pointer are taken.
    always_comb begin
        in_refill_s   = (state_q == FETCH) || (state_q == DRAIN);
        resp_accept_s = resp_v_i && in_refill_s &&
                        !buf_valid_s[resp_offset_i] && (resp_offset_i >= wr_ptr_q);
        unexpected_s  = resp_v_i && !resp_accept_s;
        resp_s.offset = icache_refill_offset_width_gp'(resp_offset_i);
        resp_s.instr  = resp_instr_i;
    end

    icache_refill_buffer #(
        .els_p(icache_block_size_in_words_p)
    ) buffer (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clear_i     (clear_s),
        .resp_v_i    (resp_accept_s),
        .resp_i      (resp_s),
        .rd_en_i     (in_refill_s),
        .rd_ptr_i    (wr_ptr_q),
        .valid_o     (buf_valid_s),
        .head_v_o    (head_v_s),
        .head_instr_o(head_instr_s)
    );

    // Next-state, request issue and in-order drain decisions.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        req_cnt_d    = req_cnt_q;
        wr_ptr_d     = wr_ptr_q;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
        crit_d       = crit_q;
`endif
        clear_s      = 1'b0;
        miss_ready_s = 1'b0;
        req_v_s      = 1'b0;
        wr_v_s       = 1'b0;
        done_s       = 1'b0;
        case (state_q)
            IDLE: begin
                miss_ready_s = 1'b1;
                if (miss_v_i) begin
                    base_d    = miss_pc_i[pc_width_lp-1:ow_lp];
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
                    crit_d    = miss_pc_i[ow_lp-1:0];
`endif
                    req_cnt_d = '0;
                    wr_ptr_d  = '0;
                    clear_s   = 1'b1;
                    state_d   = FETCH;
                end else begin
                    state_d   = IDLE;
                end
            end
            FETCH: begin
                req_v_s = 1'b1;
                if (req_ready_i) begin
                    req_cnt_d = req_cnt_q + one_lp;
                    state_d   = (req_cnt_q == last_lp) ? DRAIN : FETCH;
                end else begin
                    state_d   = FETCH;
                end
            end
            DRAIN:   state_d = DRAIN;
            DONE: begin
                done_s  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Drain overrides: the final in-order write ends the refill, even mid-issue.
        if (head_v_s) begin
            wr_v_s   = 1'b1;
            wr_ptr_d = wr_ptr_q + one_lp;
            if (wr_ptr_q == last_lp) begin
                state_d = DONE;
            end else begin
                state_d = state_d;
            end
        end else begin
            wr_v_s = 1'b0;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            wr_ptr_q  <= '0;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
            crit_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
            crit_q    <= crit_d;
`endif
        end
    end

    // Outputs are masked while reset is held so an abort writes nothing further.
    assign miss_ready_o      = reset_n_i & miss_ready_s;
    assign req_v_o           = reset_n_i & req_v_s;
    assign req_addr_o        = req_v_o ? {base_q, req_off_s} : '0;
    assign icache_v_o        = reset_n_i & wr_v_s;
    assign icache_w_o        = icache_v_o;
    assign icache_w_pc_o     = icache_v_o ? {base_q, wr_ptr_q} : '0;
    assign icache_w_instr_o  = icache_v_o ? head_instr_s : 32'h0000_0000;
    assign refill_done_o     = reset_n_i & done_s;
    assign unexpected_resp_o = reset_n_i & unexpected_s;

endmodule
